// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, buffers one fetched word for decode, handles start/halt/redirect.
// Optional FETCH_BOUNDS_CHECK_EN: faults on a fetch attempt beyond the instruction memory.
module fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    output logic [15:0] pc_address,
    input  logic [15:0] mem_instruction,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] instruction,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [1:0]  state,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10,
        FAULT  = 2'b11
    } state_t;

    localparam logic [15:0] LAST_PC = 16'(MEM_BYTES - 2);
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;

    logic        accept_c;
    logic        room_c;

    assign accept_c = valid_q && instr_ready;
    assign room_c   = !valid_q || instr_ready;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
            ipc_q   <= 16'h0000;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    // Next state: redirect beats halt beats load while running
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
                if (accept_c) valid_d = 1'b0;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_d    = branch_target & 16'hFFFE;
                    valid_d = 1'b0;
                    if (halt) state_d = HALTED;
                end else if (halt) begin
                    state_d = HALTED;
                    if (accept_c) valid_d = 1'b0;
                end else if (room_c) begin
                    if (CHECK_EN && (pc_q > LAST_PC)) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        instr_d = mem_instruction;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 16'd2;
                    end
                end
            end
            HALTED: begin
                if (start && !halt) state_d = RUN;
                if (accept_c) valid_d = 1'b0;
            end
            FAULT: begin
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_address  = pc_q;
    assign instruction = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign state       = state_q;
    assign fault       = fault_q & CHECK_EN;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: literal expectations plus a per-cycle spec-level model.
module tb_fetch_sequencer;

    localparam int unsigned MEM_BYTES = 128;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, halt, branch_taken, instr_ready;
    logic [15:0] branch_target;
    logic [15:0] pc_address, mem_instruction, instruction, instr_pc;
    logic        instr_valid, fault;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory image: test bytes at 0..5, elsewhere address low byte xor A5
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] img [0:5];
        img = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        if (a < 16'd6) return img[a[2:0]];
        return a[7:0] ^ 8'hA5;
    endfunction

    assign mem_instruction = {mem_byte(pc_address), mem_byte(pc_address + 16'd1)};

    fetch_sequencer #(.MEM_BYTES(MEM_BYTES), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .pc_address(pc_address), .mem_instruction(mem_instruction),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .state(state), .fault(fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level model: mode 0 idle, 1 run, 2 halted, 3 fault
    int          m_mode;
    logic [15:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_pc <= 16'h0000; m_instr <= 16'h0000;
            m_ipc <= 16'h0000; m_valid <= 1'b0; m_fault <= 1'b0;
        end else begin
            bit running, redirect, fetch, taken;
            running  = (m_mode == 1);
            redirect = running && branch_taken;
            fetch    = running && !halt && !branch_taken && (!m_valid || instr_ready);
            taken    = m_valid && instr_ready;
            if (m_mode == 3) begin
                m_valid <= 1'b0;
            end else if (redirect) begin
                m_pc    <= {branch_target[15:1], 1'b0};
                m_valid <= 1'b0;
            end else if (fetch && CHECK && (int'(m_pc) > int'(MEM_BYTES) - 2)) begin
                m_mode  <= 3;
                m_fault <= 1'b1;
                m_valid <= 1'b0;
            end else if (fetch) begin
                m_instr <= {mem_byte(m_pc), mem_byte(m_pc + 16'd1)};
                m_ipc   <= m_pc;
                m_valid <= 1'b1;
                m_pc    <= m_pc + 16'd2;
            end else if (taken) begin
                m_valid <= 1'b0;
            end
            if (m_mode == 0 && start) m_mode <= 1;
            if (running && halt) m_mode <= 2;
            if (m_mode == 2 && start && !halt) m_mode <= 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_state", 32'(state), 32'(m_mode));
            chk("model_pc", 32'(pc_address), 32'(m_pc));
            chk("model_valid", 32'(instr_valid), 32'(m_valid));
            chk("model_instr", 32'(instruction), 32'(m_instr));
            chk("model_ipc", 32'(instr_pc), 32'(m_ipc));
            chk("model_fault", 32'(fault), 32'(m_fault));
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; instr_ready = 1'b1;
        #12;
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_pc", 32'(pc_address), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", 32'(instruction), 32'h0);
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        chk("start_run", 32'(state), 32'h1);
        chk("start_novalid", 32'(instr_valid), 32'h0);
        start = 1'b0;
        step();
        chk("w0_instr", 32'(instruction), 32'h1234);
        chk("w0_ipc", 32'(instr_pc), 32'h0);
        chk("w0_valid", 32'(instr_valid), 32'h1);
        step();
        chk("w1_instr", 32'(instruction), 32'h5678);
        chk("w1_ipc", 32'(instr_pc), 32'h2);
        step();
        chk("w2_instr", 32'(instruction), 32'h9ABC);
        chk("w2_ipc", 32'(instr_pc), 32'h4);

        // Backpressure holds word and PC
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_instr", 32'(instruction), 32'h9ABC);
            chk("bp_pc", 32'(pc_address), 32'h6);
        end
        instr_ready = 1'b1;
        step();
        chk("bp_next_instr", 32'(instruction), 32'hA3A2);
        chk("bp_next_ipc", 32'(instr_pc), 32'h6);

        // Redirect to odd target: one bubble, bit 0 dropped
        branch_taken = 1'b1; branch_target = 16'h0011;
        step();
        chk("br_bubble", 32'(instr_valid), 32'h0);
        chk("br_pc", 32'(pc_address), 32'h0010);
        branch_taken = 1'b0;
        step();
        chk("br_instr", 32'(instruction), 32'hB5B4);
        chk("br_ipc", 32'(instr_pc), 32'h0010);
        chk("br_pcnext", 32'(pc_address), 32'h0012);

        // Halt with a pending word
        instr_ready = 1'b0;
        step();
        halt = 1'b1;
        step();
        chk("halt_state", 32'(state), 32'h2);
        chk("halt_held", 32'(instr_valid), 32'h1);
        halt = 1'b0; instr_ready = 1'b1;
        step();
        chk("halt_drained", 32'(instr_valid), 32'h0);
        step();
        chk("halt_frozen_pc", 32'(pc_address), 32'h0012);
        chk("halt_nofetch", 32'(instr_valid), 32'h0);
        start = 1'b1;
        step();
        chk("resume_state", 32'(state), 32'h1);
        start = 1'b0;
        step();
        chk("resume_instr", 32'(instruction), 32'hB7B6);
        chk("resume_ipc", 32'(instr_pc), 32'h0012);

        // Last in-range word, then one past memory
        branch_taken = 1'b1; branch_target = 16'h007E;
        step();
        branch_taken = 1'b0;
        step();
        chk("edge_instr", 32'(instruction), 32'hDBDA);
        chk("edge_ipc", 32'(instr_pc), 32'h007E);
        step();
        if (CHECK) begin
            chk("oob_state", 32'(state), 32'h3);
            chk("oob_fault", 32'(fault), 32'h1);
            chk("oob_valid", 32'(instr_valid), 32'h0);
            chk("oob_pc", 32'(pc_address), 32'h0080);
        end else begin
            chk("oob_instr", 32'(instruction), 32'h2524);
            chk("oob_ipc", 32'(instr_pc), 32'h0080);
            chk("oob_fault", 32'(fault), 32'h0);
        end
        step();
        step();

        // Asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'h0);
        chk("arst_pc", 32'(pc_address), 32'h0);
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_instr", 32'(instruction), 32'h0);
        chk("arst_ipc", 32'(instr_pc), 32'h0);
        chk("arst_fault", 32'(fault), 32'h0);
        step();
        rst_n = 1'b1;

        // Directed mixed vectors, checked by the model each cycle
        start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            instr_ready   = (i % 3) != 0;
            branch_taken  = (i % 7) == 3;
            branch_target = 16'(i * 6 + 1);
            halt          = (i == 20) || (i == 21) || (i == 40);
            start         = (i < 2) || (i == 25) || (i == 45);
            step();
        end
        start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
